// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus used by the fetch stage.
// The master issues one word-address request at a time and receives
// exactly one response per accepted request.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: holds the PC, issues one request at a time
// to a variable-latency instruction memory and drives the IF/ID register.
// Delay-slot semantics: an in-flight fetch is never killed; a redirect only
// steers the fetch that follows it.
// Optional macro IF_ALIGN_CHECK_EN adds d_exc_adel and suppresses fetches of
// misaligned or out-of-window PCs, delivering a flagged nop instead.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset,
  if_fetch_stage_if.master       imem,
  input  logic                   stall,
  input  logic                   br_valid,
  input  logic [31:0]            br_target,
  output logic                   d_valid,
  output logic [31:0]            d_instr,
  output logic [31:0]            d_pc,
  output logic [31:0]            d_pc8
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic                   d_exc_adel
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc8_q, d_pc8_d;

  logic        pc_bad;
  logic        take;
  logic        leave;
  logic        br_take;
  logic        dlv;
  logic [31:0] dlv_instr;
  logic [31:0] dlv_pc;

`ifdef IF_ALIGN_CHECK_EN
  logic        buf_exc_q, buf_exc_d;
  logic        d_exc_q, d_exc_d;
  logic        dlv_exc;

  assign pc_bad = (pc_q[1:0] != 2'b00) ||
                  (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_6FFF);
  assign d_exc_adel = d_exc_q;
`else
  assign pc_bad = 1'b0;
`endif

  // Request is gated by reset so nothing is issued while reset is held.
  assign imem.imem_req  = (state_q == S_REQ) && !pc_bad && reset;
  assign imem.imem_addr = pc_q;
  assign br_take        = br_valid && !stall;

  assign d_valid = d_valid_q;
  assign d_instr = d_instr_q;
  assign d_pc    = d_pc_q;
  assign d_pc8   = d_pc8_q;

  // Fetch FSM, next-PC/redirect tracking and IF/ID load decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fpc_d        = fpc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    d_valid_d    = d_valid_q;
    d_instr_d    = d_instr_q;
    d_pc_d       = d_pc_q;
    d_pc8_d      = d_pc8_q;
    take         = 1'b0;
    dlv          = 1'b0;
    dlv_instr    = 32'd0;
    dlv_pc       = 32'd0;
`ifdef IF_ALIGN_CHECK_EN
    buf_exc_d    = buf_exc_q;
    d_exc_d      = d_exc_q;
    dlv_exc      = 1'b0;
`endif

    unique case (state_q)
      S_REQ: begin
        if (pc_bad) begin
          // Bad PC: no memory access, a nop behaves as if it had arrived.
          take = 1'b1;
          if (!stall) begin
            dlv    = 1'b1;
            dlv_pc = pc_q;
`ifdef IF_ALIGN_CHECK_EN
            dlv_exc = 1'b1;
`endif
          end else begin
            buf_instr_d = 32'd0;
            buf_pc_d    = pc_q;
`ifdef IF_ALIGN_CHECK_EN
            buf_exc_d   = 1'b1;
`endif
            state_d     = S_HOLD;
          end
        end else if (imem.imem_ready) begin
          take    = 1'b1;
          fpc_d   = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (!stall) begin
            dlv       = 1'b1;
            dlv_instr = imem.imem_rdata;
            dlv_pc    = fpc_q;
            state_d   = S_REQ;
          end else begin
            buf_instr_d = imem.imem_rdata;
            buf_pc_d    = fpc_q;
`ifdef IF_ALIGN_CHECK_EN
            buf_exc_d   = 1'b0;
`endif
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          dlv       = 1'b1;
          dlv_instr = buf_instr_q;
          dlv_pc    = buf_pc_q;
`ifdef IF_ALIGN_CHECK_EN
          dlv_exc   = buf_exc_q;
`endif
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect seen while the delay slot is in flight replaces the
    // already-advanced PC as we return to REQ; one seen in REQ waits for
    // the current (delay-slot) request to be accepted.
    leave = (state_q != S_REQ) && (state_d == S_REQ);
    if (take) begin
      if (br_take)           pc_d = br_target;
      else if (redir_pend_q) pc_d = redir_tgt_q;
      else                   pc_d = pc_q + 32'd4;
      redir_pend_d = 1'b0;
    end else if (leave) begin
      if (br_take)           pc_d = br_target;
      else if (redir_pend_q) pc_d = redir_tgt_q;
      redir_pend_d = 1'b0;
    end else if (br_take) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = br_target;
    end

    // IF/ID holds under stall; otherwise a cycle without delivery is a bubble.
    if (!stall) begin
      d_valid_d = dlv;
      if (dlv) begin
        d_instr_d = dlv_instr;
        d_pc_d    = dlv_pc;
        d_pc8_d   = dlv_pc + 32'd8;
`ifdef IF_ALIGN_CHECK_EN
        d_exc_d   = dlv_exc;
`endif
      end
    end
  end

  // State register; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      fpc_q        <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'd0;
      buf_instr_q  <= 32'd0;
      buf_pc_q     <= 32'd0;
      d_valid_q    <= 1'b0;
      d_instr_q    <= 32'd0;
      d_pc_q       <= 32'd0;
      d_pc8_q      <= 32'd0;
`ifdef IF_ALIGN_CHECK_EN
      buf_exc_q    <= 1'b0;
      d_exc_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      d_valid_q    <= d_valid_d;
      d_instr_q    <= d_instr_d;
      d_pc_q       <= d_pc_d;
      d_pc8_q      <= d_pc8_d;
`ifdef IF_ALIGN_CHECK_EN
      buf_exc_q    <= buf_exc_d;
      d_exc_q      <= d_exc_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a granted-handshake memory model
// with programmable response delay, and a scoreboard of expected deliveries.
module tb_if_fetch_stage;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        d_valid;
  logic [31:0] d_instr, d_pc, d_pc8;
`ifdef IF_ALIGN_CHECK_EN
  logic        d_exc_adel;
`endif

  if_fetch_stage_if bus ();

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (bus.master),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .d_valid   (d_valid),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .d_pc8     (d_pc8)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .d_exc_adel(d_exc_adel)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: ready only while unused grants remain.
  int          grants_given = 0;
  int          grants_used = 0;
  int          hs_cnt = 0;
  int          delay = 0;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic        rv_r = 1'b0;
  logic [31:0] rd_r = 32'd0;
  logic        stray = 1'b0;

  assign bus.imem_ready  = (grants_given != grants_used);
  assign bus.imem_rvalid = rv_r | stray;
  assign bus.imem_rdata  = stray ? 32'hDEAD_BEEF : rd_r;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_r <= 1'b0;
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      rv_r <= 1'b0;
      if (bus.imem_req && bus.imem_ready) begin
        grants_used <= grants_used + 1;
        hs_cnt      <= hs_cnt + 1;
        rd_r        <= bus.imem_addr ^ MASK;
        if (delay == 0) rv_r <= 1'b1;
        else begin
          pend <= 1'b1;
          cnt  <= delay - 1;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          rv_r <= 1'b1;
          pend <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   n_push = 0;
  int   deliv_cnt = 0;
  int   last_dcyc = 0;
  int   cyc = 0;
  logic stall_s = 1'b0;

  always @(posedge clk) begin
    stall_s <= stall;
    cyc     <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (reset && !stall_s && d_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dv", {31'b0, d_valid}, 32'd0);
      end else begin
        e_m = exp_q.pop_front();
        chk("d_pc", d_pc, e_m.pc);
        chk("d_instr", d_instr, e_m.instr);
        chk("d_pc8", d_pc8, e_m.pc + 32'd8);
`ifdef IF_ALIGN_CHECK_EN
        chk("d_exc", {31'b0, d_exc_adel}, {31'b0, e_m.exc});
`endif
      end
      deliv_cnt++;
      last_dcyc = cyc;
    end
  end

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.instr = pc ^ MASK; e.exc = 1'b0;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic push_exc(input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.instr = 32'd0; e.exc = 1'b1;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_deliv(input int n, input string tag);
    int t = 0;
    while (deliv_cnt < n && t < 200) begin
      step();
      t++;
    end
    if (deliv_cnt < n) chk({tag, "_timeout"}, deliv_cnt, n);
  endtask

  task automatic wait_hs(input int n, input string tag);
    int t = 0;
    while (hs_cnt < n && t < 200) begin
      step();
      t++;
    end
    if (hs_cnt < n) chk({tag, "_timeout"}, hs_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c1;
    int h0;

    // Reset state
    repeat (3) step();
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_3000);
    chk("rst_dv", {31'b0, d_valid}, 32'd0);
    chk("rst_dinstr", d_instr, 32'd0);
    chk("rst_dpc", d_pc, 32'd0);
    chk("rst_dpc8", d_pc8, 32'd0);
    reset = 1'b1;
    #1;
    chk("req_after_rel", {31'b0, bus.imem_req}, 32'd1);

    // Sequential fetch with zero-wait memory
    delay = 0;
    push(32'h3000); push(32'h3004); push(32'h3008);
    grants_given += 3;
    wait_deliv(1, "t1a");
    c1 = last_dcyc;
    wait_deliv(3, "t1b");
    chk("t1_gap", last_dcyc - c1, 32'd4);

    // Ready held low: request and address must stay stable
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_req", {31'b0, bus.imem_req}, 32'd1);
      chk("t4_addr", bus.imem_addr, 32'h0000_300C);
    end
    h0 = hs_cnt;
    push(32'h300C);
    grants_given++;
    wait_deliv(n_push, "t4");
    chk("t4_hs_once", hs_cnt - h0, 32'd1);

    // Stall across acceptance and response
    delay = 1;
    stall = 1'b1;
    h0 = hs_cnt;
    push(32'h3010);
    grants_given++;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_dpc", d_pc, 32'h0000_300C);
      chk("t2_dinstr", d_instr, 32'h0000_300C ^ MASK);
      chk("t2_dv", {31'b0, d_valid}, 32'd1);
    end
    chk("t2_hs", hs_cnt - h0, 32'd1);
    stall = 1'b0;
    wait_deliv(n_push, "t2");
    step();
    chk("t2_bubble", {31'b0, d_valid}, 32'd0);

    // Redirect while the delay slot is in WAIT
    delay = 1;
    h0 = hs_cnt;
    push(32'h3014); push(32'h3100); push(32'h3104);
    grants_given += 3;
    wait_hs(h0 + 1, "t3_hs");
    br_valid = 1'b1; br_target = 32'h3100;
    step();
    br_valid = 1'b0;
    wait_deliv(n_push, "t3");

    // Redirect in REQ with same-cycle acceptance
    push(32'h3108); push(32'h3200);
    grants_given += 2;
    br_valid = 1'b1; br_target = 32'h3200;
    step();
    br_valid = 1'b0;
    wait_deliv(n_push, "t3b");

    // Back-to-back redirects: latest target wins
    delay = 2;
    h0 = hs_cnt;
    push(32'h3204); push(32'h3400);
    grants_given += 2;
    wait_hs(h0 + 1, "t3c_hs");
    br_valid = 1'b1; br_target = 32'h3300;
    step();
    br_target = 32'h3400;
    step();
    br_valid = 1'b0;
    wait_deliv(n_push, "t3c");

    // Reset in WAIT, stray response right after release
    delay = 3;
    h0 = hs_cnt;
    grants_given++;
    wait_hs(h0 + 1, "t5_hs");
    step();
    reset = 1'b0;
    #1;
    chk("t5_req", {31'b0, bus.imem_req}, 32'd0);
    chk("t5_addr", bus.imem_addr, 32'h0000_3000);
    chk("t5_dv", {31'b0, d_valid}, 32'd0);
    chk("t5_dpc", d_pc, 32'd0);
    chk("t5_dinstr", d_instr, 32'd0);
    step(); step();
    reset = 1'b1;
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("t5_stray_dv", {31'b0, d_valid}, 32'd0);
    chk("t5_stray_req", {31'b0, bus.imem_req}, 32'd1);
    chk("t5_stray_addr", bus.imem_addr, 32'h0000_3000);
    delay = 0;
    push(32'h3000);
    grants_given++;
    wait_deliv(n_push, "t5");

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned redirect target: flagged nop, no memory request
    delay = 1;
    h0 = hs_cnt;
    push(32'h3004);
    grants_given++;
    wait_hs(h0 + 1, "al_hs");
    br_valid = 1'b1; br_target = 32'h3002;
    step();
    br_valid = 1'b0;
    wait_deliv(n_push, "al_a");
    chk("al_noreq", {31'b0, bus.imem_req}, 32'd0);
    h0 = hs_cnt;
    push_exc(32'h3002);
    br_valid = 1'b1; br_target = 32'h3020;
    step();
    br_valid = 1'b0;
    chk("al_exc_out", {31'b0, d_exc_adel}, 32'd1);
    chk("al_hs_none", hs_cnt - h0, 32'd0);
    push(32'h3020);
    grants_given++;
    wait_deliv(n_push, "al_b");
`endif

    repeat (4) step();
    chk("sb_drained", exp_q.size(), 32'd0);
    chk("deliv_total", deliv_cnt, n_push);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Holds the PC and issues one request at a time to a variable-latency instruction memory.
- Delivers fetched instructions to the IF/ID boundary and feeds the decode stage.
- Obeys stalls from the hazard unit and branch/jump redirects from ID. Uses MIPS delay-slot semantics: the in-flight fetch is never killed.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; first fetch address.

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset==0 clears state immediately)
imem_req  out  1  fetch request valid
imem_addr  out  32  word address of request, held stable while imem_req=1
imem_ready  in  1  memory accepts request this cycle (handshake: imem_req & imem_ready)
imem_rvalid  in  1  response valid, exactly one per accepted request
imem_rdata  in  32  instruction word, valid with imem_rvalid
stall  in  1  hazard unit: hold IF/ID outputs and PC
br_valid  in  1  redirect from ID; sampled only when stall=0
br_target  in  32  redirect target PC
d_valid  out  1  IF/ID register holds a real instruction
d_instr  out  32  IF/ID instruction
d_pc  out  32  PC of d_instr
d_pc8  out  32  d_pc+8 (jal/jalr link value)

Behaviour:
- Reset values:
  - pc=RESET_PC; state=REQ.
  - imem_req=0 during reset; asserts in the first cycle after release.
  - imem_addr=RESET_PC.
  - d_valid=0, d_instr=0, d_pc=0, d_pc8=0.
  - redir_pend=0; buffer empty.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc. On imem_ready, latch fpc=pc and go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - stall=0: load IF/ID with {imem_rdata, fpc, fpc+8}, d_valid=1, go to REQ.
    - stall=1: capture into 1-entry buffer, go to HOLD.
  - HOLD: on stall=0, move buffer into IF/ID, d_valid=1, go to REQ.
- Bubbles: in any cycle with stall=0 and no instruction delivered, d_valid<=0. d_instr and d_pc keep their old values.
- stall=1: IF/ID outputs unchanged. The REQ handshake may still complete, because the request address does not depend on ID.
- Next-PC update on handshake acceptance: pc<=pc+4. If redir_pend=1, instead pc<=redir_tgt and redir_pend<=0.
- Redirect (br_valid=1 and stall=0):
  - In REQ with acceptance the same cycle: the current request is the delay slot; pc<=br_target for the following fetch.
  - In REQ without acceptance, or in WAIT/HOLD: record redir_pend=1, redir_tgt=br_target. The pending/buffered instruction (delay slot) is still delivered.
  - Back-to-back br_valid: the latest target overwrites redir_tgt.
- Arithmetic: 32-bit, wraps modulo 2^32. No alignment check unless the optional feature is enabled.
- At most one outstanding request. imem_rvalid outside WAIT is ignored.
- Reset asserted mid-transaction: all state is cleared. Any late imem_rvalid arriving while state=REQ after reset is ignored.
- Latency: an instruction appears on d_* the cycle after imem_rvalid if stall=0. Zero-wait memory (ready=1, rvalid the next cycle) gives one instruction every 2 cycles.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN
- Defined:
  - Adds output port d_exc_adel (1 bit; reset 0).
  - If pc[1:0]!=0 or pc is outside 0x0000_3000..0x0000_6FFF in REQ: no memory request is issued.
  - IF/ID loads d_instr=32'h0000_0000 (nop), d_pc=pc, d_exc_adel=1, d_valid=1, obeying stall as if data had arrived.
  - PC then follows the normal next-PC rule.
  - d_exc_adel=0 for all normal deliveries.
- Undefined: no port, no check; misaligned PCs are fetched as-is.

Test Plan:
- Reset release, ready=1, rvalid one cycle after acceptance, rdata=pc ^ 32'hA5A5_0000 -> d_pc sequence 0x3000, 0x3004, 0x3008; d_pc8=d_pc+8; d_valid pulses every 2nd cycle.
- stall=1 for 3 cycles while in WAIT; rvalid arrives during the stall -> d_* unchanged, buffer holds 0x3004. After stall drops, d_pc=0x3004 the next cycle, and no instruction is lost or duplicated.
- br_valid with target 0x3100 while the delay slot 0x3008 is in WAIT -> 0x3008 delivered, next imem_addr=0x3100, then 0x3104.
- imem_ready low for 4 cycles -> imem_req and imem_addr=0x300C held stable throughout; a single handshake follows.
- reset pulled low while in WAIT, then released; a stray rvalid arrives in the first cycle after release -> outputs at reset values, the stray rvalid is ignored, fetch restarts at 0x3000.
- With IF_ALIGN_CHECK_EN, br_target=0x3002 -> no imem_req for 0x3002; d_exc_adel=1, d_instr=0, d_pc=0x3002.
